// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multicycle sequencer: op codes, FSM states,
// arithmetic unit indices and the op-to-unit decode.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpNop   = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpDiv   = 3'd3,
    OpDivu  = 3'd4,
    OpMthi  = 3'd5,
    OpMtlo  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StCommit
  } state_e;

  localparam logic [1:0] UnitMult  = 2'd0;
  localparam logic [1:0] UnitMultu = 2'd1;
  localparam logic [1:0] UnitDiv   = 2'd2;
  localparam logic [1:0] UnitDivu  = 2'd3;

  typedef struct packed {
    logic       valid;
    logic       is_div;
    logic [1:0] sel;
  } unit_dec_t;

  function automatic unit_dec_t decode_unit(op_e op);
    unit_dec_t d;
    d = '0;
    unique case (op)
      OpMult:  begin d.valid = 1'b1; d.sel = UnitMult;  end
      OpMultu: begin d.valid = 1'b1; d.sel = UnitMultu; end
      OpDiv:   begin d.valid = 1'b1; d.is_div = 1'b1; d.sel = UnitDiv;  end
      OpDivu:  begin d.valid = 1'b1; d.is_div = 1'b1; d.sel = UnitDivu; end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Controller-facing request/status signals plus the arithmetic unit
// start/result bus; slave is the sequencer, master is controller and units.
interface muldiv_sequencer_if;
  logic        req;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic        dz;
  logic        timeout;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [3:0]  unit_start;
  logic [1:0]  unit_sel;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic [3:0]  unit_done;
  logic [31:0] unit_hi;
  logic [31:0] unit_lo;

  modport master (
    output req, op, rs, rt, unit_done, unit_hi, unit_lo,
    input  busy, done, dz, timeout, hi, lo, unit_start, unit_sel, unit_a, unit_b
  );

  modport slave (
    input  req, op, rs, rt, unit_done, unit_hi, unit_lo,
    output busy, done, dz, timeout, hi, lo, unit_start, unit_sel, unit_a, unit_b
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Starts one multiply/divide unit per request, waits for its completion or a
// timeout, and commits the 64-bit result into the architectural HI/LO pair.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  sel_q, sel_d;
  logic        dz_q, dz_d, to_q, to_d;

  op_e       op;
  unit_dec_t dec;
  logic      busy, accept, is_mt, div_zero, unit_hit, expire;

  assign op       = op_e'(bus.op);
  assign dec      = decode_unit(op);
  assign busy     = (state_q == StIssue) || (state_q == StWait);
  // COMMIT is not busy, so a back-to-back request is taken there as in IDLE
  assign accept   = bus.req && !busy;
  assign is_mt    = (op == OpMthi) || (op == OpMtlo);
  assign div_zero = dec.valid && dec.is_div && (bus.rt == '0);
  assign unit_hit = bus.unit_done[sel_q];
  assign expire   = (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StCommit: begin
        state_d = StIdle;
        if (accept) begin
          if (is_mt || div_zero) begin
            state_d = StCommit;
          end else if (dec.valid) begin
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (unit_hit || expire) state_d = StCommit;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy       = busy;
    bus.done       = (state_q == StCommit);
    bus.unit_start = '0;
    if (state_q == StIssue) bus.unit_start[sel_q] = 1'b1;
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    a_d   = a_q;
    b_d   = b_q;
    sel_d = sel_q;
    dz_d  = dz_q;
    to_d  = to_q;
    cnt_d = '0;
    if (accept && (is_mt || dec.valid)) begin
      dz_d = 1'b0;
      to_d = 1'b0;
      if (op == OpMthi) hi_d = bus.rs;
      if (op == OpMtlo) lo_d = bus.rs;
      if (dec.valid) begin
        a_d   = bus.rs;
        b_d   = bus.rt;
        sel_d = dec.sel;
        dz_d  = div_zero;
      end
    end
    if (state_q == StWait) begin
      cnt_d = cnt_q + 8'd1;
      // completion beats a simultaneous expiry
      if (unit_hit) begin
        hi_d = bus.unit_hi;
        lo_d = bus.unit_lo;
      end else if (expire) begin
        to_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sel_q <= '0;
      dz_q  <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sel_q <= sel_d;
      dz_q  <= dz_d;
      to_q  <= to_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.unit_a   = a_q;
  assign bus.unit_b   = b_q;
  assign bus.unit_sel = sel_q;
  assign bus.dz       = dz_q;
  assign bus.timeout  = to_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a timeline model (cycles since
// acceptance) is compared every cycle, plus literal expectations per op.
module tb_muldiv_sequencer;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_sequencer_if bus ();

  muldiv_sequencer #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: an accepted unit op is in flight until the first edge at age >= 2
  // with its unit's done bit, or until age TO+1, whichever comes first.
  logic        m_inflight = 1'b0, m_done = 1'b0, m_dz = 1'b0, m_to = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
  logic [1:0]  m_sel = '0;
  int          m_age = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_inflight = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_to = 1'b0;
      m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_sel = '0; m_age = 0;
    end else begin
      m_done = 1'b0;
      if (m_inflight) begin
        m_age++;
        if (m_age >= 2 && bus.unit_done[m_sel]) begin
          m_hi = bus.unit_hi; m_lo = bus.unit_lo; m_inflight = 1'b0; m_done = 1'b1;
        end else if (m_age == TO + 1) begin
          m_to = 1'b1; m_inflight = 1'b0; m_done = 1'b1;
        end
      end else if (bus.req) begin
        case (bus.op)
          3'd5: begin m_hi = bus.rs; m_dz = 1'b0; m_to = 1'b0; m_done = 1'b1; end
          3'd6: begin m_lo = bus.rs; m_dz = 1'b0; m_to = 1'b0; m_done = 1'b1; end
          3'd1, 3'd2, 3'd3, 3'd4: begin
            m_a = bus.rs; m_b = bus.rt; m_sel = 2'(bus.op - 3'd1);
            m_dz = 1'b0; m_to = 1'b0;
            if (bus.op >= 3'd3 && bus.rt == 0) begin
              m_dz = 1'b1; m_done = 1'b1;
            end else begin
              m_inflight = 1'b1; m_age = 0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      chk("busy", bus.busy, m_inflight);
      chk("done", bus.done, m_done);
      chk("dz", bus.dz, m_dz);
      chk("timeout", bus.timeout, m_to);
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
      chk("unit_start", bus.unit_start,
          (m_inflight && m_age == 0) ? (4'b0001 << m_sel) : 4'b0000);
      chk("unit_sel", bus.unit_sel, m_sel);
      chk("unit_a", bus.unit_a, m_a);
      chk("unit_b", bus.unit_b, m_b);
    end
  end

  // Issue one request; the unit model pulses done `delay` cycles after the
  // start cycle (delay < 0: never). Latency to done is 0 if no pulse arrives.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int delay, input logic [31:0] uhi,
                        input logic [31:0] ulo, input int exp_lat, output int starts,
                        output logic [3:0] start_val, output int busy_cyc);
    int lat;
    logic [3:0] ubit;
    ubit = (op >= 3'd1 && op <= 3'd4) ? (4'b0001 << (op - 3'd1)) : 4'b0000;
    @(negedge clk);
    bus.req = 1'b1; bus.op = op; bus.rs = rs; bus.rt = rt;
    lat = 0; starts = 0; start_val = '0; busy_cyc = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.req = 1'b0; bus.op = 3'd0; end
      if (bus.unit_start != 0) begin starts++; start_val = bus.unit_start; end
      if (bus.busy) busy_cyc++;
      if (bus.done) lat = k;
      bus.unit_done = (delay >= 0 && k == 1 + delay) ? ubit : 4'b0000;
      bus.unit_hi = uhi;
      bus.unit_lo = ulo;
    end
    bus.unit_done = 4'b0000;
    chk({name, " latency"}, lat, exp_lat);
  endtask

  int         st, bc;
  logic [3:0] sv;
  bit         done_seen;

  initial begin
    bus.req = 1'b0; bus.op = '0; bus.rs = '0; bus.rt = '0;
    bus.unit_done = '0; bus.unit_hi = '0; bus.unit_lo = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset hi", bus.hi, 32'h0);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset unit_start", bus.unit_start, 4'b0);
    reset = 1'b0;

    run_op("mthi", 3'd5, 32'h1234_5678, 32'h0, -1, 32'h0, 32'h0, 1, st, sv, bc);
    chk("mthi hi", bus.hi, 32'h1234_5678);
    chk("mthi busy cycles", bc, 0);

    run_op("mtlo", 3'd6, 32'hCAFE_F00D, 32'h0, -1, 32'h0, 32'h0, 1, st, sv, bc);
    chk("mtlo lo", bus.lo, 32'hCAFE_F00D);

    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 7, st, sv, bc);
    chk("mult start count", st, 1);
    chk("mult start value", sv, 4'b0001);
    chk("mult hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult lo", bus.lo, 32'hFFFF_FFFA);

    run_op("divu0", 3'd4, 32'd77, 32'd0, -1, 32'h0, 32'h0, 1, st, sv, bc);
    chk("divu0 start count", st, 0);
    chk("divu0 dz", bus.dz, 1'b1);
    chk("divu0 hi", bus.hi, 32'hFFFF_FFFF);
    chk("divu0 lo", bus.lo, 32'hFFFF_FFFA);

    run_op("multu", 3'd2, 32'd7, 32'd9, 2, 32'd0, 32'd63, 4, st, sv, bc);
    chk("multu dz cleared", bus.dz, 1'b0);
    chk("multu start value", sv, 4'b0010);
    chk("multu lo", bus.lo, 32'd63);

    run_op("div timeout", 3'd3, 32'd40, 32'd6, -1, 32'h0, 32'h0, 10, st, sv, bc);
    chk("div timeout flag", bus.timeout, 1'b1);
    chk("div timeout hi", bus.hi, 32'd0);
    chk("div timeout lo", bus.lo, 32'd63);

    run_op("divu at expiry", 3'd4, 32'd100, 32'd7, 8, 32'd2, 32'd14, 10, st, sv, bc);
    chk("divu expiry timeout", bus.timeout, 1'b0);
    chk("divu expiry hi", bus.hi, 32'd2);
    chk("divu expiry lo", bus.lo, 32'd14);

    run_op("divu fast", 3'd4, 32'd9, 32'd2, 1, 32'd1, 32'd4, 3, st, sv, bc);
    chk("divu fast lo", bus.lo, 32'd4);

    run_op("nop", 3'd0, 32'hDEAD_BEEF, 32'd1, -1, 32'h0, 32'h0, 0, st, sv, bc);
    chk("nop hi", bus.hi, 32'd1);

    // DIV wait: stray other-unit done, dropped request, then reset
    done_seen = 1'b0;
    @(negedge clk);
    bus.req = 1'b1; bus.op = 3'd3; bus.rs = 32'd50; bus.rt = 32'd5;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
      bus.req = 1'b0; bus.op = 3'd0; bus.unit_done = 4'b0000; reset = 1'b0;
      if (k == 2) bus.unit_done = 4'b0001;
      if (k == 3) begin bus.req = 1'b1; bus.op = 3'd5; bus.rs = 32'hDEAD_BEEF; end
      if (k == 4) reset = 1'b1;
      if (k == 5) begin
        chk("midreset busy", bus.busy, 1'b0);
        chk("midreset hi", bus.hi, 32'd0);
        chk("midreset lo", bus.lo, 32'd0);
      end
    end
    chk("midwait no done", done_seen, 1'b0);

    run_op("mult after reset", 3'd1, 32'd3, 32'd5, 3, 32'd0, 32'd15, 5, st, sv, bc);
    chk("mult after reset lo", bus.lo, 32'd15);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequences the multicycle HI/LO arithmetic units (signed/unsigned multiplier, signed/unsigned divider) on behalf of the multicycle controller. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request at a time and starts exactly one unit. It waits for that unit's completion, then commits the 64-bit result into the architectural HI/LO registers it owns. It sits between the controller, which stalls on `busy`, and the four arithmetic units; it replaces the per-unit start strobes and HI/LO write muxes.

## Interface
- `TIMEOUT`, 64: maximum cycles spent waiting for `unit_done`; must be ≥2 and ≤255.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: request strobe, sampled only when `busy`=0.
- `op` in 3: operation code (see package).
- `rs` in 32: operand A, or the MTHI/MTLO source.
- `rt` in 32: operand B.
- `busy` out 1: operation in flight; the controller stalls while high.
- `done` out 1: one-cycle completion pulse.
- `dz` out 1: last DIV/DIVU had `rt`=0; sticky until the next accepted request.
- `timeout` out 1: last unit operation timed out; sticky until the next accepted request.
- `hi`, `lo` out 32 each: architectural HI/LO.
- `unit_start` out 4: one-hot start pulse; bit0 MULT, bit1 MULTU, bit2 DIV, bit3 DIVU.
- `unit_sel` out 2: index of the active unit; drives the external result mux.
- `unit_a`, `unit_b` out 32 each: latched operands.
- `unit_done` in 4: per-unit completion pulse.
- `unit_hi`, `unit_lo` in 32 each: result of the unit selected by `unit_sel`.

Reset values: `busy`=0, `done`=0, `dz`=0, `timeout`=0, `hi`=`lo`=0, `unit_start`=0, `unit_sel`=0, `unit_a`=`unit_b`=0.

## Operation
- States: IDLE, ISSUE, WAIT, COMMIT.
- IDLE:
  - `req`=1 with a unit op: latch `rs`/`rt` into `unit_a`/`unit_b`, set `unit_sel`, clear `dz` and `timeout`, go to ISSUE.
  - MTHI/MTLO: write `hi`/`lo` from `rs` at the accepting edge, then go to COMMIT.
  - DIV/DIVU with `rt`=0: no unit is started. Set `dz`, go to COMMIT; HI/LO stay unchanged.
  - NOP or an undefined op: ignored, stay in IDLE.
- ISSUE: `unit_start[unit_sel]`=1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - `unit_done[unit_sel]`=1: capture `unit_hi`/`unit_lo` into `hi`/`lo` at that edge, go to COMMIT.
  - Counter reaches `TIMEOUT` first: set `timeout`, go to COMMIT; HI/LO stay unchanged.
- COMMIT: `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in ISSUE and WAIT; `busy`=0 in IDLE and COMMIT.
- `unit_done` bits of non-selected units are ignored in all states. `unit_done` is also ignored in IDLE and ISSUE.
- `req` while `busy`=1 is dropped, not queued.
- If `unit_done` and timeout expiry occur in the same cycle, `unit_done` wins and `timeout` stays 0.
- Reset mid-operation: returns to IDLE next edge. `unit_start` is cleared immediately at that edge and HI/LO are zeroed. No `done` is issued.

## Timing
- Request accepted at edge N (`req`=1, `busy`=0).
- MTHI/MTLO and the divide-by-zero path:
  - Result (or `dz`) visible after edge N.
  - `done`=1 in cycle N+1, `busy` never rises.
  - Total latency is 1 cycle.
- Unit op:
  - `unit_start` is high in cycle N+1 and `busy` is high from cycle N+1.
  - If `unit_done` is sampled high at edge M (M ≥ N+2), HI/LO update after M.
  - `done`=1 and `busy`=0 in cycle M+1.
  - A new request can be accepted at edge M+1.
- `unit_a`/`unit_b`/`unit_sel` are stable from edge N until the next acceptance.
- Timeout: `done` is asserted at most `TIMEOUT`+2 cycles after acceptance.

## Structure
- Package `muldiv_pkg` holds:
  - op codes: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6;
  - state encoding;
  - unit index constants: MULT=0, MULTU=1, DIV=2, DIVU=3.
- The module is a single unit with no sub-modules. The op-to-unit decode is a combinational function in the package.

## Test plan
- Reset, then MTHI with `rs`=0x12345678 → `hi`=0x12345678 after one edge; `done` pulses once; `busy` stays 0.
- MULT with `rs`=0xFFFFFFFE, `rt`=3, and a model unit returning `unit_done` 5 cycles after start with HI=0xFFFFFFFF, LO=0xFFFFFFFA → `unit_start`=0001 for one cycle; HI/LO committed; `done` at cycle 7 after acceptance.
- DIVU with `rt`=0 → no `unit_start`, `dz`=1, HI/LO unchanged, `done` after 1 cycle. A following MULTU clears `dz`.
- DIV whose model never asserts `unit_done`, with `TIMEOUT`=8 → `timeout`=1, `done` at cycle 10 after acceptance, HI/LO unchanged.
- During a DIV wait:
  - a stray `unit_done[0]` pulse → ignored;
  - a `req` → dropped;
  - `reset` asserted mid-wait → IDLE, HI/LO=0, no `done`.
